// File: rtl/nvdla_mcif_wr_eg_pkg.sv
// Shared encodings and cq_rd_pd field layout for the MCIF write egress block.
package nvdla_mcif_wr_eg_pkg;

  typedef enum logic [1:0] {
    AXI_OKAY   = 2'b00,
    AXI_EXOKAY = 2'b01,
    AXI_SLVERR = 2'b10,
    AXI_DECERR = 2'b11
  } axi_resp_e;

  // Each client owns a {len, require_ack} slice, require_ack in the LSB.
  function automatic int pd_w(input int len_w);
    return len_w + 1;
  endfunction

  function automatic int pd_ack_off(input int idx, input int len_w);
    return idx * (len_w + 1);
  endfunction

  function automatic int pd_len_off(input int idx, input int len_w);
    return idx * (len_w + 1) + 1;
  endfunction

endpackage

// File: rtl/nvdla_mcif_wr_eg_bhold.sv
// Single-entry B-response holding register; refills in the cycle it drains.
module nvdla_mcif_wr_eg_bhold
  import nvdla_mcif_wr_eg_pkg::*;
#(
  parameter int NUM_CLIENTS = 5,
  parameter int ID_W        = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            b_vld_i,
  output logic            b_rdy_o,
  input  logic [ID_W-1:0] b_id_i,
  input  logic [1:0]      b_resp_i,
  input  logic            cq_hit_i,
  output logic            hold_vld_o,
  output logic [ID_W-1:0] hold_id_o,
  output logic [1:0]      hold_resp_o,
  output logic            in_rng_o,
  output logic            pop_o,
  output logic            stall_o
);

  // Widened compare keeps every ID bit significant, even for narrow ID_W.
  localparam int CW = ID_W + 5;

  logic            hold_vld_q, hold_vld_d;
  logic [ID_W-1:0] hold_id_q, hold_id_d;
  logic [1:0]      hold_resp_q, hold_resp_d;

  assign in_rng_o = CW'(hold_id_q) < CW'(NUM_CLIENTS);
  assign pop_o    = hold_vld_q & ~rst_i & (~in_rng_o | cq_hit_i);
  assign stall_o  = hold_vld_q & ~rst_i & in_rng_o & ~cq_hit_i;
  assign b_rdy_o  = ~rst_i & (~hold_vld_q | pop_o);

  always_comb begin
    hold_vld_d  = hold_vld_q;
    hold_id_d   = hold_id_q;
    hold_resp_d = hold_resp_q;
    if (pop_o) hold_vld_d = 1'b0;
    if (b_vld_i && b_rdy_o) begin
      hold_vld_d  = 1'b1;
      hold_id_d   = b_id_i;
      hold_resp_d = b_resp_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_vld_q  <= 1'b0;
      hold_id_q   <= '0;
      hold_resp_q <= '0;
    end else begin
      hold_vld_q  <= hold_vld_d;
      hold_id_q   <= hold_id_d;
      hold_resp_q <= hold_resp_d;
    end
  end

  assign hold_vld_o  = hold_vld_q;
  assign hold_id_o   = hold_id_q;
  assign hold_resp_o = hold_resp_q;

endmodule

// File: rtl/nvdla_mcif_write_eg_param.sv
// MCIF write egress: matches AXI B responses to client context queues.
// Optional NVDLA_MCIF_WR_EG_RESP_ERR_EN enables sticky per-client bresp errors.
module nvdla_mcif_write_eg_param
  import nvdla_mcif_wr_eg_pkg::*;
#(
  parameter int NUM_CLIENTS = 5,
  parameter int ID_W        = 8,
  parameter int LEN_W       = 2,
  parameter int CNT_W       = 16
) (
  input  logic                               nvdla_core_clk,
  input  logic                               nvdla_core_rst,
  input  logic                               noc2mcif_axi_b_bvalid,
  output logic                               noc2mcif_axi_b_bready,
  input  logic [ID_W-1:0]                    noc2mcif_axi_b_bid,
  input  logic [1:0]                         noc2mcif_axi_b_bresp,
  input  logic [NUM_CLIENTS-1:0]             cq_rd_pvld,
  output logic [NUM_CLIENTS-1:0]             cq_rd_prdy,
  input  logic [NUM_CLIENTS*(LEN_W+1)-1:0]   cq_rd_pd,
  output logic [NUM_CLIENTS-1:0]             mcif2client_wr_rsp_complete,
  output logic                               eg2ig_axi_vld,
  output logic [LEN_W-1:0]                   eg2ig_axi_len,
  output logic [NUM_CLIENTS-1:0]             rsp_err,
  input  logic [NUM_CLIENTS-1:0]             rsp_err_clr,
  output logic                               bad_id,
  output logic [CNT_W-1:0]                   stall_cnt
);

  localparam int CW = ID_W + 5;

  logic                              hold_vld, in_rng, pop, stall, cq_hit;
  logic [ID_W-1:0]                   hold_id;
  logic [1:0]                        hold_resp;
  logic [NUM_CLIENTS-1:0]            sel, ack, prdy;
  logic [NUM_CLIENTS-1:0][LEN_W-1:0] len;
  logic [LEN_W-1:0]                  len_sel;

  logic [NUM_CLIENTS-1:0] cmpl_q, cmpl_d;
  logic                   eg_vld_q, eg_vld_d;
  logic [LEN_W-1:0]       eg_len_q, eg_len_d;
  logic                   bad_q, bad_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  nvdla_mcif_wr_eg_bhold #(.NUM_CLIENTS(NUM_CLIENTS), .ID_W(ID_W)) u_bhold (
    .clk_i       (nvdla_core_clk),
    .rst_i       (nvdla_core_rst),
    .b_vld_i     (noc2mcif_axi_b_bvalid),
    .b_rdy_o     (noc2mcif_axi_b_bready),
    .b_id_i      (noc2mcif_axi_b_bid),
    .b_resp_i    (noc2mcif_axi_b_bresp),
    .cq_hit_i    (cq_hit),
    .hold_vld_o  (hold_vld),
    .hold_id_o   (hold_id),
    .hold_resp_o (hold_resp),
    .in_rng_o    (in_rng),
    .pop_o       (pop),
    .stall_o     (stall)
  );

  for (genvar i = 0; i < NUM_CLIENTS; i++) begin : g_cl
    localparam int AOFF = pd_ack_off(i, LEN_W);
    localparam int LOFF = pd_len_off(i, LEN_W);
    assign ack[i] = cq_rd_pd[AOFF];
    assign len[i] = cq_rd_pd[LOFF +: LEN_W];
    assign sel[i] = hold_vld & (CW'(hold_id) == CW'(i));
  end

  assign cq_hit = |(sel & cq_rd_pvld);
  assign prdy   = pop ? sel : '0;

  always_comb begin
    len_sel = '0;
    for (int i = 0; i < NUM_CLIENTS; i++)
      if (sel[i]) len_sel = len_sel | len[i];
    cmpl_d   = prdy & ack;
    eg_vld_d = pop & in_rng;
    eg_len_d = eg_vld_d ? len_sel : '0;
    bad_d    = bad_q | (pop & ~in_rng);
    cnt_d    = cnt_q;
    // The counter reports the length of the most recent stall until it drains.
    if (stall) begin
      if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
    end else if (pop) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      cmpl_q   <= '0;
      eg_vld_q <= 1'b0;
      eg_len_q <= '0;
      bad_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      cmpl_q   <= cmpl_d;
      eg_vld_q <= eg_vld_d;
      eg_len_q <= eg_len_d;
      bad_q    <= bad_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef NVDLA_MCIF_WR_EG_RESP_ERR_EN
  logic [NUM_CLIENTS-1:0] err_q, err_d;

  // Set is applied after the clear so a same-cycle error wins.
  assign err_d = (err_q & ~rsp_err_clr) | (hold_resp != AXI_OKAY ? prdy : '0);

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) err_q <= '0;
    else                err_q <= err_d;
  end

  assign rsp_err = err_q;
`else
  logic unused_resp_err;
  assign unused_resp_err = ^{hold_resp, rsp_err_clr};
  assign rsp_err = '0;
`endif

  assign cq_rd_prdy                  = prdy;
  assign mcif2client_wr_rsp_complete = cmpl_q;
  assign eg2ig_axi_vld               = eg_vld_q;
  assign eg2ig_axi_len               = eg_len_q;
  assign bad_id                      = bad_q;
  assign stall_cnt                   = cnt_q;

endmodule
